// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS core's data-side bridge.
//   bridge_state_t  - dmem_bridge FSM state (2-bit)
//   BUS_ABORT_DATA  - load data returned when a bus transaction is aborted
//   ALIGN_MASK      - low address bits that must be zero for a word access
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bridge_state_t;

  localparam logic [31:0] BUS_ABORT_DATA = 32'hDEAD_BEEF;
  localparam logic [1:0]  ALIGN_MASK     = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return |(addr_lsb & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/dmem_bridge_bus_timer.sv
// bus_timer: counts REQ cycles without an ack and flags expiry.
// Only instantiated when DMEM_BRIDGE_TIMEOUT_EN is defined.
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset
//   i_clr     - load the counter with zero (entry to REQ)
//   i_en      - a REQ cycle with no ack; advances the counter
//   o_expired - this enabled cycle is the TMO_CYCLES-th one without ack
module bus_timer #(
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Counter holds the number of waiting cycles already spent, so the
  // TMO_CYCLES-th waiting cycle is the one that sees LAST.
  assign o_expired = i_en && (r_count == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the single-cycle core's zero-wait data access into a
// registered req/ack bus transaction, stalling the core while it is in flight.
// Misaligned accesses never reach the bus; they and bus errors set err_sticky.
// Optional: define DMEM_BRIDGE_TIMEOUT_EN to abort a request after TMO_CYCLES
// cycles without ack (returns BUS_ABORT_DATA and sets err_sticky).
// Ports:
//   clk, reset                 - clock; asynchronous active-low reset
//   cpu_memread, cpu_memwrite  - core access request (both high = write)
//   cpu_addr, cpu_wdata        - byte address and store data from the core
//   cpu_rdata                  - load data to the core
//   stall                      - freezes the core's PC and regfile writes
//   bus_req/bus_we/bus_addr/bus_wdata - registered bus request
//   bus_ack/bus_rdata/bus_err  - bus completion, read data, error qualifier
//   err_sticky, err_clr        - latched error flag and its synchronous clear
module dmem_bridge
  import mips_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_memread,
  input  logic          cpu_memwrite,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_err,
  output logic          err_sticky,
  input  logic          err_clr
);

  bridge_state_t r_state, w_state_nxt;
  logic          r_bus_req, w_bus_req_nxt;
  logic          r_bus_we, w_bus_we_nxt;
  logic [AW-1:0] r_bus_addr, w_bus_addr_nxt;
  logic [DW-1:0] r_bus_wdata, w_bus_wdata_nxt;
  logic [DW-1:0] r_rdata, w_rdata_nxt;
  logic          r_err;

  logic w_acc, w_misalign, w_start, w_bad_acc, w_ack, w_tmo, w_tmr_en, w_err_set;

  assign w_acc      = cpu_memread | cpu_memwrite;
  assign w_misalign = is_misaligned(cpu_addr[1:0]);
  assign w_start    = (r_state == IDLE) && w_acc && !w_misalign;
  assign w_bad_acc  = (r_state == IDLE) && w_acc && w_misalign;
  assign w_ack      = (r_state == REQ) && bus_ack;
  assign w_tmr_en   = (r_state == REQ) && !bus_ack;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  // Ack wins over timeout: the timer only advances in cycles without ack.
  bus_timer #(
    .TMO_CYCLES(TMO_CYCLES)
  ) u_bus_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_start),
    .i_en     (w_tmr_en),
    .o_expired(w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_bus_req_nxt   = r_bus_req;
    w_bus_we_nxt    = r_bus_we;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_wdata_nxt = r_bus_wdata;
    w_rdata_nxt     = r_rdata;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt     = REQ;
          w_bus_req_nxt   = 1'b1;
          w_bus_we_nxt    = cpu_memwrite;
          w_bus_addr_nxt  = cpu_addr;
          w_bus_wdata_nxt = cpu_wdata;
        end
      end
      REQ: begin
        if (w_ack) begin
          w_state_nxt   = DONE;
          w_bus_req_nxt = 1'b0;
          if (!r_bus_we) begin
            w_rdata_nxt = bus_rdata;
          end
        end else if (w_tmo) begin
          w_state_nxt   = DONE;
          w_bus_req_nxt = 1'b0;
          w_rdata_nxt   = DW'(BUS_ABORT_DATA);
        end
      end
      // The finishing instruction's access is still visible here; going
      // straight to IDLE keeps it from being issued a second time.
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_bus_we    <= w_bus_we_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
    end
  end

  // A new error event takes priority over a clear in the same cycle.
  assign w_err_set = w_bad_acc || (w_ack && bus_err) || w_tmo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  // Stall is combinational so the core freezes in the very cycle it issues;
  // gating with reset keeps it low while reset is asserted.
  assign stall      = reset && (w_start || (r_state == REQ));
  assign cpu_rdata  = w_bad_acc ? '0 : r_rdata;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign err_sticky = r_err;

endmodule

// File: tb/tb_dmem_bridge.sv
`timescale 1ns/1ps
module tb_dmem_bridge;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_memread = 1'b0;
  logic        cpu_memwrite = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;
  logic        err_sticky;
  logic        err_clr = 1'b0;

  dmem_bridge #(
    .AW(32),
    .DW(32),
    .TMO_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_memread (cpu_memread),
    .cpu_memwrite(cpu_memwrite),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .stall       (stall),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .bus_err     (bus_err),
    .err_sticky  (err_sticky),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: memory contents, last loaded word, error flag.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] m_rd = '0;
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One aligned access; the memory acks in REQ cycle n (n >= 1).
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int n, input logic err);
    int stalls = 0;
    int reqs = 0;
    logic [31:0] rd_val;
    if (!we) begin
      if (!mem.exists(addr)) mem[addr] = $urandom;
      rd_val = mem[addr];
      m_rd   = rd_val;
    end else begin
      mem[addr] = wd;
      rd_val    = '0;
    end
    m_err = m_err | err;
    cpu_memread  = we ? 1'($urandom) : 1'b1;
    cpu_memwrite = we;
    cpu_addr     = addr;
    cpu_wdata    = wd;
    // Ack in IDLE must be ignored.
    bus_ack   = 1'($urandom);
    bus_rdata = $urandom;
    bus_err   = 1'($urandom);
    @(negedge clk);
    chkb("idle_no_req", bus_req, 1'b0);
    if (stall) stalls++;
    @(posedge clk); #1;
    for (int k = 1; k <= n; k++) begin
      bus_ack   = (k == n);
      bus_err   = (k == n) ? err : 1'($urandom);
      bus_rdata = (k == n && !we) ? rd_val : $urandom;
      @(negedge clk);
      if (stall) stalls++;
      if (bus_req) reqs++;
      chkb("bus_we", bus_we, we);
      chk("bus_addr", bus_addr, addr);
      chk("bus_wdata", bus_wdata, wd);
      @(posedge clk); #1;
    end
    // DONE cycle: a stray ack here must also be ignored.
    bus_ack   = 1'($urandom);
    bus_rdata = $urandom;
    bus_err   = 1'($urandom);
    @(negedge clk);
    chkb("done_stall", stall, 1'b0);
    chkb("done_req", bus_req, 1'b0);
    chk("done_rdata", cpu_rdata, m_rd);
    chkb("done_err", err_sticky, m_err);
    chk("stall_cycles", stalls, n + 1);
    chk("req_cycles", reqs, n);
    @(posedge clk); #1;
    cpu_memread  = 1'b0;
    cpu_memwrite = 1'b0;
    bus_ack      = 1'b0;
    bus_err      = 1'b0;
  endtask

  task automatic misalign(input logic we, input logic [31:0] addr, input logic clr);
    cpu_memread  = !we;
    cpu_memwrite = we;
    cpu_addr     = addr;
    err_clr      = clr;
    @(negedge clk);
    chkb("mis_stall", stall, 1'b0);
    chkb("mis_req", bus_req, 1'b0);
    chk("mis_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    cpu_memread  = 1'b0;
    cpu_memwrite = 1'b0;
    err_clr      = 1'b0;
    m_err        = 1'b1;
    @(negedge clk);
    chkb("mis_err", err_sticky, 1'b1);
    chkb("mis_req_after", bus_req, 1'b0);
    chk("mis_rdata_after", cpu_rdata, m_rd);
    @(posedge clk); #1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_err   = 1'b0;
    @(negedge clk);
    chkb("clr_err", err_sticky, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] v;
    int tcnt;

    // Reset values, with an aligned load pending to confirm stall stays low.
    cpu_memread = 1'b1;
    cpu_addr    = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("rst_stall", stall, 1'b0);
    chkb("rst_req", bus_req, 1'b0);
    chkb("rst_we", bus_we, 1'b0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chkb("rst_err", err_sticky, 1'b0);
    @(posedge clk); #1;
    cpu_memread = 1'b0;
    reset       = 1'b1;
    @(posedge clk); #1;

    // Load, ack in first REQ cycle; store with ack in fifth REQ cycle.
    mem[32'h40] = 32'h1234_5678;
    access(1'b0, 32'h40, $urandom, 1, 1'b0);
    chk("t1_rdata", m_rd, 32'h1234_5678);
    access(1'b1, 32'h44, 32'hCAFE_F00D, 5, 1'b0);

    // Misaligned load, then clear.
    misalign(1'b0, 32'h41, 1'b0);
    clear_err();

    // Read with bus error, then back-to-back store and load of the same word.
    access(1'b0, 32'h48, $urandom, 2, 1'b1);
    clear_err();
    v = $urandom;
    access(1'b1, 32'h4C, v, 1, 1'b0);
    access(1'b0, 32'h4C, $urandom, 3, 1'b0);
    chk("b2b_rdata", m_rd, v);

    // Clear and misalign in the same cycle: set wins.
    misalign(1'b1, 32'h52, 1'b1);
    clear_err();

    // Randomized traffic over a small address window.
    for (int i = 0; i < 40; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      if ($urandom_range(0, 9) == 0) begin
        misalign(1'($urandom), a | 32'($urandom_range(1, 3)), 1'($urandom));
      end else begin
        access(1'($urandom), a, $urandom, int'($urandom_range(1, 6)),
               ($urandom_range(0, 7) == 0));
      end
      if (m_err && $urandom_range(0, 1) == 1) clear_err();
    end

    // Reset two cycles into REQ; a late ack afterwards is ignored.
    cpu_memread = 1'b1;
    cpu_addr    = 32'h80;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chkb("pre_rst_req", bus_req, 1'b1);
    reset = 1'b0;
    #1;
    chkb("async_rst_req", bus_req, 1'b0);
    chkb("async_rst_stall", stall, 1'b0);
    cpu_memread = 1'b0;
    m_rd  = '0;
    m_err = 1'b0;
    @(posedge clk); #1;
    reset     = 1'b1;
    bus_ack   = 1'b1;
    bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chkb("late_ack_req", bus_req, 1'b0);
    chkb("late_ack_stall", stall, 1'b0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_rdata", cpu_rdata, m_rd);
    chkb("late_ack_err", err_sticky, 1'b0);
    chkb("late_ack_idle", bus_req, 1'b0);
    @(posedge clk); #1;

    // Load that is never acked.
    cpu_memread = 1'b1;
    cpu_addr    = 32'hC0;
    @(posedge clk); #1;
    tcnt = 0;
    @(negedge clk);
    while (bus_req === 1'b1 && tcnt < 40) begin
      tcnt++;
      @(negedge clk);
    end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    m_rd  = 32'hDEAD_BEEF;
    m_err = 1'b1;
    chk("tmo_req_cycles", tcnt, TMO);
    chkb("tmo_stall", stall, 1'b0);
    chk("tmo_rdata", cpu_rdata, m_rd);
    chkb("tmo_err", err_sticky, m_err);
`else
    chk("notmo_req_cycles", tcnt, 40);
    chkb("notmo_stall", stall, 1'b1);
    v         = $urandom;
    m_rd      = v;
    bus_ack   = 1'b1;
    bus_rdata = v;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chkb("notmo_done_stall", stall, 1'b0);
    chk("notmo_rdata", cpu_rdata, m_rd);
    chkb("notmo_err", err_sticky, m_err);
`endif
    @(posedge clk); #1;
    cpu_memread = 1'b0;
    @(negedge clk);
    chkb("final_idle_req", bus_req, 1'b0);
    chkb("final_idle_stall", stall, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
